// File: rtl/vga_reg_fetch_sched_if.sv
// Bus bundle between the sprite-register fetch scheduler, the port-B side of
// the register RAM, the sprite engines and the frame/semaphore control.
interface vga_reg_fetch_sched_if #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 9,
    parameter int NUM_SPRITES      = 8,
    parameter int WORDS_PER_SPRITE = 4
);
    localparam int SPRITE_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int WORD_W   = (WORDS_PER_SPRITE > 1) ? $clog2(WORDS_PER_SPRITE) : 1;

    logic                  frame_start;
    logic                  v_sync;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_rd;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_valid;
    logic [SPRITE_W-1:0]   ld_sprite;
    logic [WORD_W-1:0]     ld_word;
    logic                  busy;
    logic                  done;
    logic                  sem_flag;
    logic                  overrun;

    // The scheduler side
    modport master (
        input  frame_start, v_sync, base_addr, ram_q,
        output ram_addr, ram_rd, ld_data, ld_valid, ld_sprite, ld_word,
               busy, done, sem_flag, overrun
    );

    // The surrounding system: frame timing, RAM port B and sprite engines
    modport slave (
        output frame_start, v_sync, base_addr, ram_q,
        input  ram_addr, ram_rd, ld_data, ld_valid, ld_sprite, ld_word,
               busy, done, sem_flag, overrun
    );
endinterface

// File: rtl/vga_reg_fetch_sched.sv
// Once-per-frame burst fetch of the sprite descriptor table from register RAM
// port B. Each returned word is tagged with its sprite/word index and handed
// to the sprite engines; a frame semaphore is raised when the burst completes
// and dropped again at vertical sync.
module vga_reg_fetch_sched #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 9,
    parameter int NUM_SPRITES      = 8,
    parameter int WORDS_PER_SPRITE = 4,
    parameter int RAM_LATENCY      = 2
) (
    input logic px_clk,
    input logic rst,
    vga_reg_fetch_sched_if.master bus
);
    localparam int TOTAL    = NUM_SPRITES * WORDS_PER_SPRITE;
    localparam int K_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int SPRITE_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int WORD_W   = (WORDS_PER_SPRITE > 1) ? $clog2(WORDS_PER_SPRITE) : 1;

    localparam logic [K_W-1:0]         K_LAST    = K_W'(TOTAL - 1);
    localparam logic [K_W-1:0]         K_WORDS   = K_W'(WORDS_PER_SPRITE);
    localparam logic [RAM_LATENCY-1:0] LAST_MASK = RAM_LATENCY'(1) << (RAM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   issue;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [K_W-1:0]         k;
    logic [SPRITE_W-1:0]    k_sprite;
    logic [WORD_W-1:0]      k_word;
    logic [RAM_LATENCY-1:0] valid_pipe;
    logic [SPRITE_W-1:0]    sprite_pipe [RAM_LATENCY];
    logic [WORD_W-1:0]      word_pipe   [RAM_LATENCY];
    logic                   sem_q;
    logic                   overrun_q;

    // A frame start is only taken when no fetch is in flight
    assign accept   = (state == IDLE) && bus.frame_start;
    assign k_sprite = SPRITE_W'(k / K_WORDS);
    assign k_word   = WORD_W'(k % K_WORDS);

    // FSM state register
    always_ff @(posedge px_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state: issue TOTAL reads, wait out the RAM latency, pulse done
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.frame_start) state_next = ISSUE;
            ISSUE: if (k == K_LAST) state_next = DRAIN;
            DRAIN: if ((valid_pipe & ~LAST_MASK) == '0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        issue    = (state == ISSUE);
        bus.ram_rd = issue;
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
    end

    // Base latch and word counter; the counter parks on the last index so the
    // address holds its final value while idle
    always_ff @(posedge px_clk) begin
        if (rst) begin
            base_q <= '0;
            k      <= '0;
        end else if (accept) begin
            base_q <= bus.base_addr;
            k      <= '0;
        end else if (issue && (k != K_LAST)) begin
            k <= k + 1'b1;
        end
    end

    // Valid/tag shift pipeline tracking each read through the RAM latency
    always_ff @(posedge px_clk) begin
        if (rst) begin
            valid_pipe <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                sprite_pipe[i] <= '0;
                word_pipe[i]   <= '0;
            end
        end else begin
            valid_pipe[0]  <= issue;
            sprite_pipe[0] <= k_sprite;
            word_pipe[0]   <= k_word;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                valid_pipe[i]  <= valid_pipe[i-1];
                sprite_pipe[i] <= sprite_pipe[i-1];
                word_pipe[i]   <= word_pipe[i-1];
            end
        end
    end

    // Frame semaphore (completion beats v_sync) and sticky overrun flag
    always_ff @(posedge px_clk) begin
        if (rst) begin
            sem_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (state == DONE)   sem_q <= 1'b1;
            else if (bus.v_sync) sem_q <= 1'b0;
            if (bus.frame_start && (state != IDLE)) overrun_q <= 1'b1;
        end
    end

    assign bus.ram_addr  = base_q + ADDR_WIDTH'(k);
    assign bus.ld_data   = bus.ram_q;
    assign bus.ld_valid  = valid_pipe[RAM_LATENCY-1];
    assign bus.ld_sprite = sprite_pipe[RAM_LATENCY-1];
    assign bus.ld_word   = word_pipe[RAM_LATENCY-1];
    assign bus.sem_flag  = sem_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_vga_reg_fetch_sched.sv
// Self-checking bench for vga_reg_fetch_sched: a RAM model with fixed read
// latency, a per-cycle reference model of the scheduler and queues of expected
// addresses and load words that are matched against the DUT each cycle.
module tb_vga_reg_fetch_sched;
    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int NS    = 8;
    localparam int WPS   = 4;
    localparam int LAT   = 2;
    localparam int TOTAL = NS * WPS;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } addr_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [2:0]    spr;
        logic [1:0]    wrd;
    } ld_t;

    logic px_clk = 1'b0;
    logic rst    = 1'b1;
    logic mon_en = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] q1;
    logic [DW-1:0] q2;

    addr_t addr_q[$];
    ld_t   ld_q[$];
    addr_t a_tmp;
    ld_t   l_tmp;
    int    exp_done = -1;
    int    busy_lo  = 0;
    int    busy_hi  = -1;
    logic  sem_model = 1'b0;
    logic  ovr_model = 1'b0;
    logic  exp_rd;
    logic  exp_ld;

    vga_reg_fetch_sched_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .NUM_SPRITES(NS), .WORDS_PER_SPRITE(WPS)
    ) bus ();

    vga_reg_fetch_sched #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SPRITES(NS),
        .WORDS_PER_SPRITE(WPS), .RAM_LATENCY(LAT)
    ) dut (
        .px_clk(px_clk),
        .rst(rst),
        .bus(bus)
    );

    // Pixel clock
    always #5 px_clk = ~px_clk;

    // Cycle counter, read by stimulus and monitor away from the edge
    always @(posedge px_clk) cyc <= cyc + 1;

    // Register RAM port B: two registered stages give the read latency
    always @(posedge px_clk) begin
        q1 <= mem[bus.ram_addr];
        q2 <= q1;
    end
    assign bus.ram_q = q2;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic vs, input logic r, input logic [AW-1:0] b);
        @(posedge px_clk);
        #1;
        bus.frame_start = fs;
        bus.v_sync      = vs;
        bus.base_addr   = b;
        rst             = r;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'h0);
        checkOutput({tag, "_ram_rd"}, 32'(bus.ram_rd), 32'h0);
        checkOutput({tag, "_ld_valid"}, 32'(bus.ld_valid), 32'h0);
        checkOutput({tag, "_ld_sprite"}, 32'(bus.ld_sprite), 32'h0);
        checkOutput({tag, "_ld_word"}, 32'(bus.ld_word), 32'h0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'h0);
        checkOutput({tag, "_sem_flag"}, 32'(bus.sem_flag), 32'h0);
        checkOutput({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
    endtask

    // Reference model and scoreboard: compare this cycle, then predict the next
    always @(negedge px_clk) begin
        if (mon_en) begin
            exp_rd = (addr_q.size() > 0) && (addr_q[0].cyc == cyc);
            checkOutput("ram_rd", 32'(bus.ram_rd), 32'(exp_rd));
            if (exp_rd) begin
                checkOutput("ram_addr", 32'(bus.ram_addr), 32'(addr_q[0].addr));
                void'(addr_q.pop_front());
            end

            exp_ld = (ld_q.size() > 0) && (ld_q[0].cyc == cyc);
            checkOutput("ld_valid", 32'(bus.ld_valid), 32'(exp_ld));
            if (exp_ld) begin
                checkOutput("ld_data", 32'(bus.ld_data), 32'(ld_q[0].data));
                checkOutput("ld_sprite", 32'(bus.ld_sprite), 32'(ld_q[0].spr));
                checkOutput("ld_word", 32'(bus.ld_word), 32'(ld_q[0].wrd));
                void'(ld_q.pop_front());
            end

            checkOutput("done", 32'(bus.done), 32'(cyc == exp_done));
            checkOutput("busy", 32'(bus.busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            checkOutput("sem_flag", 32'(bus.sem_flag), 32'(sem_model));
            checkOutput("overrun", 32'(bus.overrun), 32'(ovr_model));

            if (rst) begin
                addr_q.delete();
                ld_q.delete();
                exp_done  <= -1;
                busy_lo   <= 0;
                busy_hi   <= -1;
                sem_model <= 1'b0;
                ovr_model <= 1'b0;
            end else begin
                if (cyc == exp_done)  sem_model <= 1'b1;
                else if (bus.v_sync)  sem_model <= 1'b0;
                if (bus.frame_start) begin
                    if (cyc > busy_hi) begin
                        for (int k = 0; k < TOTAL; k++) begin
                            a_tmp.cyc  = cyc + 1 + k;
                            a_tmp.addr = AW'(int'(bus.base_addr) + k);
                            addr_q.push_back(a_tmp);
                            l_tmp.cyc  = cyc + 1 + k + LAT;
                            l_tmp.data = mem[a_tmp.addr];
                            l_tmp.spr  = 3'(k / WPS);
                            l_tmp.wrd  = 2'(k % WPS);
                            ld_q.push_back(l_tmp);
                        end
                        exp_done <= cyc + TOTAL + LAT + 1;
                        busy_lo  <= cyc + 1;
                        busy_hi  <= cyc + TOTAL + LAT + 1;
                    end else begin
                        ovr_model <= 1'b1;
                    end
                end
            end
        end
    end

    // Directed sequence: reset, nominal, wrap, semaphore, overrun, back-to-back, mid-fetch reset
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        bus.frame_start = 1'b0;
        bus.v_sync      = 1'b0;
        bus.base_addr   = '0;

        repeat (2) @(posedge px_clk);
        #1;
        mon_en = 1'b1;
        checkResetOutputs("por");

        $display("[TB] nominal frame, base 0x040");
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h040);
        idleCycles(36);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        idleCycles(2);

        $display("[TB] wrapping frame, base 0x1F0, v_sync in the done cycle");
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h1F0);
        idleCycles(34);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        idleCycles(2);

        $display("[TB] overrun at cycle 10 and back-to-back frame at cycle 36");
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h100);
        idleCycles(9);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
        idleCycles(25);
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h0A0);
        idleCycles(36);
        checkOutput("overrun_sticky", 32'(bus.overrun), 32'h1);
        checkOutput("sem_held_b2b", 32'(bus.sem_flag), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        idleCycles(2);

        $display("[TB] reset mid-fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h080);
        idleCycles(4);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkResetOutputs("midrst");
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        idleCycles(40);

        $display("[TB] recovery frame, base 0x1FC");
        applyStimulus(1'b1, 1'b0, 1'b0, 9'h1FC);
        idleCycles(40);

        checkOutput("addr_queue_empty", 32'(addr_q.size()), 32'h0);
        checkOutput("ld_queue_empty", 32'(ld_q.size()), 32'h0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_reg_fetch_sched.md
# vga_reg_fetch_sched

Pixel-clock-domain scheduler that, once per frame, walks the sprite-register region of the dual-port register RAM through its read port (port B), tags each returned word with its sprite/word index and presents it to the sprite engines as a load strobe. It replaces fixed per-register enable sequencing with a parameterised burst fetch. It also maintains the frame semaphore the CPU polls: set when a fetch completes, cleared at vertical sync.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 9, RAM port-B address width (512 words)
- NUM_SPRITES, 8, sprites fetched per frame (power of two, ≥1)
- WORDS_PER_SPRITE, 4, descriptor words per sprite (power of two, ≥1)
- RAM_LATENCY, 2, px_clk cycles from address presented to ram_q valid (≥1)

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle pulse at start of active frame
- v_sync  in  1  vertical sync level; clears semaphore
- base_addr  in  ADDR_WIDTH  first RAM word of sprite table, sampled on accepted frame_start
- ram_addr  out  ADDR_WIDTH  port-B read address
- ram_rd  out  1  address valid this cycle
- ram_q  in  DATA_WIDTH  port-B read data
- ld_data  out  DATA_WIDTH  word to sprite engines (= ram_q)
- ld_valid  out  1  ld_data valid this cycle
- ld_sprite  out  log2(NUM_SPRITES) (min 1)  target sprite of ld_data
- ld_word  out  log2(WORDS_PER_SPRITE) (min 1)  word index within descriptor
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse after last word delivered
- sem_flag  out  1  frame semaphore to CPU-side synchroniser
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- TOTAL = NUM_SPRITES*WORDS_PER_SPRITE; word counter k, 0..TOTAL-1.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on frame_start -> ISSUE, latch base_addr, k=0, busy=1.
- ISSUE: ram_rd=1, ram_addr=(base+k) mod 2^ADDR_WIDTH (wraps past top of RAM); tag {k/WORDS, k%WORDS} enters a RAM_LATENCY-deep valid/tag shift pipeline. After k=TOTAL-1 -> DRAIN.
- DRAIN: ram_rd=0; stay until pipeline empty (RAM_LATENCY cycles) -> DONE.
- DONE: done=1 for one cycle, sem_flag set -> IDLE.
- ld_valid/ld_sprite/ld_word are pipeline outputs; ld_data is ram_q passed through.
- frame_start while not IDLE: ignored, overrun set (sticky until rst).
- sem_flag: set in DONE; cleared when v_sync=1. DONE and v_sync in same cycle: set wins.
- ram_addr holds last value when ram_rd=0 (don't-care to consumers).

## Timing
- Reset values: ram_rd=0, ram_addr=0, ld_valid=0, ld_sprite=0, ld_word=0, busy=0, done=0, sem_flag=0, overrun=0; FSM IDLE; pipeline flushed.
- frame_start sampled at edge E0: cycle 1 (after E0) is first ISSUE cycle, ram_addr=base.
- Address k presented in cycle 1+k; matching ld_valid in cycle 1+k+RAM_LATENCY.
- ld_valid contiguous for TOTAL cycles; done in cycle TOTAL+RAM_LATENCY+1 (cycle 35 at defaults); busy high cycles 1..TOTAL+RAM_LATENCY+1, low next cycle.
- Back-to-back: frame_start in the cycle after DONE is accepted.
- rst mid-fetch: next cycle all outputs at reset values, no further ld_valid, sem_flag=0.

## Test plan
- Reset: assert rst 3 cycles mid-ISSUE -> all outputs zero next cycle, no stray ld_valid.
- Nominal frame: base=0x040, RAM[i]=i -> ram_addr 0x040..0x05F cycles 1..32; ld_valid cycles 3..34 with ld_data 0x040..0x05F, (ld_sprite,ld_word) (0,0),(0,1)..(7,3); done cycle 35; sem_flag=1 from cycle 36.
- Wrap: base=0x1F0 -> addresses 0x1F0..0x1FF then 0x000..0x00F; data order matches.
- Overrun: second frame_start at cycle 10 -> ignored, sequence unchanged, overrun=1 until rst.
- Semaphore: v_sync=1 asserted in the DONE cycle -> sem_flag=1 after; v_sync held next cycle -> sem_flag=0.
- Back-to-back: frame_start in cycle 36 -> new burst starts cycle 37, sem_flag stays set until v_sync.
